multicore_run_controller: RTL and testbench

- Parametrised run controller for an N-core jimmy array. Holds the cores in reset until a start pulse, then releases them.
- Hands each core its memory page bounds (page base for in_port_0, page limit for in_port_3).
- Detects each core's result strobe synchronously and captures the per-core result. Counts run cycles and sums results sequentially.
- Reports done/timeout status to the board-level top (LEDs, 7-segment displays).

---
 rtl/multicore_pkg.sv | 36 +++
 rtl/multicore_run_controller_strobe_fall_detect.sv | 24 ++
 rtl/multicore_run_controller.sv | 146 ++++++++++++++
 tb/tb_multicore_run_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared types, defaults and page-bound helpers for the multicore run controller.
package multicore_pkg;

  localparam int unsigned DefCores   = 4;
  localparam int unsigned DefDataW   = 8;
  localparam int unsigned DefAddrW   = 8;
  localparam int unsigned DefSumW    = 12;
  localparam int unsigned DefCycW    = 16;
  localparam int unsigned DefTimeout = 0;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StSum,
    StDone,
    StTimeout
  } run_state_e;

  // First address of core i's page; pages are equal-sized, remainder goes to the last core.
  function automatic int unsigned page_base_f(int unsigned i, int unsigned cores,
                                              int unsigned addr_w);
    int unsigned page;
    page = (32'd1 << addr_w) / cores;
    return i * page;
  endfunction

  // Last address of core i's page; the last core reaches the top of memory.
  function automatic int unsigned page_limit_f(int unsigned i, int unsigned cores,
                                               int unsigned addr_w);
    if (i == cores - 1) begin
      return (32'd1 << addr_w) - 1;
    end
    return page_base_f(i + 1, cores, addr_w) - 1;
  endfunction

endpackage

// File: rtl/multicore_run_controller_strobe_fall_detect.sv
// Per-bit registered falling-edge detector for the core result strobes.
module strobe_fall_detect #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] strobe,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] strobe_q;

  // Strobe history is kept every cycle regardless of controller state.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= strobe;
    end
  end

  assign fall = strobe_q & ~strobe;

endmodule

// File: rtl/multicore_run_controller.sv
// Run controller: holds cores in reset until start, captures per-core results on
// strobe falling edges, counts run cycles and sums the captured results serially.
module multicore_run_controller
  import multicore_pkg::*;
#(
  parameter int unsigned CORES   = DefCores,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned SUM_W   = DefSumW,
  parameter int unsigned CYC_W   = DefCycW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CORES-1:0]         core_strobe,
  input  logic [CORES*DATA_W-1:0]  core_result,
  output logic [CORES-1:0]         core_reset,
  output logic [CORES*ADDR_W-1:0]  page_base,
  output logic [CORES*ADDR_W-1:0]  page_limit,
  output logic [CORES-1:0]         done_mask,
  output logic                     busy,
  output logic                     all_done,
  output logic                     timed_out,
  output logic [SUM_W-1:0]         total,
  output logic [CYC_W-1:0]         cycles
);

  localparam int unsigned IdxW = (CORES > 1) ? $clog2(CORES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CORES - 1);
  localparam logic [CYC_W-1:0] TimeoutLast = CYC_W'(TIMEOUT - 1);

  if (SUM_W < DATA_W + $clog2(CORES + 1)) begin : g_sum_w_check
    $error("SUM_W too narrow for CORES results of DATA_W bits");
  end

  run_state_e                    state_q, state_d;
  logic [CORES-1:0]              fall, new_mask;
  logic [CORES-1:0]              done_mask_q, done_mask_d;
  logic [CORES-1:0][DATA_W-1:0]  res_q, res_d, res_in;
  logic [SUM_W-1:0]              total_q, total_d;
  logic [CYC_W-1:0]              cycles_q, cycles_d;
  logic                          timed_out_q, timed_out_d;
  logic [IdxW-1:0]               idx_q, idx_d;

  assign res_in = core_result;

  strobe_fall_detect #(
    .WIDTH (CORES)
  ) u_fall (
    .clk    (clk),
    .reset  (reset),
    .strobe (core_strobe),
    .fall   (fall)
  );

  // Edges from cores that already reported are ignored; first capture wins.
  assign new_mask = done_mask_q | fall;

  for (genvar i = 0; i < CORES; i++) begin : g_page
    assign page_base[i*ADDR_W +: ADDR_W]  = ADDR_W'(page_base_f(i, CORES, ADDR_W));
    assign page_limit[i*ADDR_W +: ADDR_W] = ADDR_W'(page_limit_f(i, CORES, ADDR_W));
  end

  // Next-state and datapath update for the run/sum sequence.
  always_comb begin
    state_d     = state_q;
    done_mask_d = done_mask_q;
    res_d       = res_q;
    total_d     = total_q;
    cycles_d    = cycles_q;
    timed_out_d = timed_out_q;
    idx_d       = idx_q;
    case (state_q)
      StIdle, StDone, StTimeout: begin
        if (start) begin
          state_d     = StRun;
          done_mask_d = '0;
          res_d       = '0;
          total_d     = '0;
          cycles_d    = '0;
          timed_out_d = 1'b0;
        end
      end
      StRun: begin
        if (cycles_q != '1) begin
          cycles_d = cycles_q + CYC_W'(1);
        end
        for (int i = 0; i < CORES; i++) begin
          if (fall[i] && !done_mask_q[i]) begin
            res_d[i] = res_in[i];
          end
        end
        done_mask_d = new_mask;
        idx_d       = '0;
        // All-done wins over a simultaneous timeout.
        if (&new_mask) begin
          state_d = StSum;
        end else if ((TIMEOUT != 0) && (cycles_q == TimeoutLast)) begin
          state_d     = StSum;
          timed_out_d = 1'b1;
        end
      end
      StSum: begin
        if (done_mask_q[idx_q]) begin
          total_d = total_q + SUM_W'(res_q[idx_q]);
        end
        idx_d = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          state_d = timed_out_q ? StTimeout : StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      done_mask_q <= '0;
      res_q       <= '0;
      total_q     <= '0;
      cycles_q    <= '0;
      timed_out_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      done_mask_q <= done_mask_d;
      res_q       <= res_d;
      total_q     <= total_d;
      cycles_q    <= cycles_d;
      timed_out_q <= timed_out_d;
      idx_q       <= idx_d;
    end
  end

  assign core_reset = (state_q == StIdle) ? '1 : '0;
  assign done_mask  = done_mask_q;
  assign busy       = (state_q == StRun) || (state_q == StSum);
  assign all_done   = (state_q == StDone);
  assign timed_out  = (state_q == StTimeout);
  assign total      = total_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_multicore_run_controller.sv
// Bench for multicore_run_controller: a behavioural model checked every cycle on a
// 4-core/TIMEOUT=100 instance, plus literal checks on that and a 3-core instance.
module tb_multicore_run_controller;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [3:0]  strobe_a = '0;
  logic [31:0] result_a = '0;
  logic [2:0]  strobe_b = '0;
  logic [23:0] result_b = '0;

  logic [3:0]  core_reset_a, done_mask_a;
  logic [31:0] page_base_a, page_limit_a;
  logic        busy_a, all_done_a, timed_out_a;
  logic [11:0] total_a;
  logic [15:0] cycles_a;

  logic [2:0]  core_reset_b, done_mask_b;
  logic [23:0] page_base_b, page_limit_b;
  logic        busy_b, all_done_b, timed_out_b;
  logic [11:0] total_b;
  logic [15:0] cycles_b;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  multicore_run_controller #(
    .CORES(4), .DATA_W(8), .ADDR_W(8), .SUM_W(12), .CYC_W(16), .TIMEOUT(TO)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .core_strobe(strobe_a),
    .core_result(result_a), .core_reset(core_reset_a), .page_base(page_base_a),
    .page_limit(page_limit_a), .done_mask(done_mask_a), .busy(busy_a),
    .all_done(all_done_a), .timed_out(timed_out_a), .total(total_a), .cycles(cycles_a)
  );

  multicore_run_controller #(
    .CORES(3), .DATA_W(8), .ADDR_W(8), .SUM_W(12), .CYC_W(16), .TIMEOUT(0)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .core_strobe(strobe_b),
    .core_result(result_b), .core_reset(core_reset_b), .page_base(page_base_b),
    .page_limit(page_limit_b), .done_mask(done_mask_b), .busy(busy_b),
    .all_done(all_done_b), .timed_out(timed_out_b), .total(total_b), .cycles(cycles_b)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of dut_a: phase 0 idle, 1 run, 2 sum, 3 done, 4 timeout.
  int       m_ph = 0;
  bit [3:0] m_mask = '0, m_prev = '0;
  int       m_res[4];
  int       m_cyc = 0, m_k = 0;
  bit       m_to = 0;

  always @(posedge clk) begin : model
    bit [3:0] fl;
    fl = m_prev & ~strobe_a;
    if (reset) begin
      m_ph = 0; m_mask = '0; m_cyc = 0; m_k = 0; m_to = 0;
      for (int i = 0; i < 4; i++) m_res[i] = 0;
    end else begin
      case (m_ph)
        0, 3, 4: if (start_a) begin
          m_ph = 1; m_mask = '0; m_cyc = 0; m_to = 0;
          for (int i = 0; i < 4; i++) m_res[i] = 0;
        end
        1: begin
          if (m_cyc < 65535) m_cyc++;
          for (int i = 0; i < 4; i++)
            if (fl[i] && !m_mask[i]) begin
              m_res[i] = int'(result_a[i*8 +: 8]);
              m_mask[i] = 1'b1;
            end
          if (m_mask == 4'hf) begin
            m_ph = 2; m_k = 0;
          end else if (TO != 0 && m_cyc == TO) begin
            m_ph = 2; m_k = 0; m_to = 1;
          end
        end
        2: begin
          m_k++;
          if (m_k == 4) m_ph = m_to ? 4 : 3;
        end
        default: m_ph = 0;
      endcase
    end
    m_prev = reset ? 4'b0 : strobe_a;
  end

  function automatic int exp_total();
    int s = 0;
    int lim = (m_ph == 2) ? m_k : ((m_ph >= 3) ? 4 : 0);
    for (int i = 0; i < lim; i++) s += m_res[i];
    return s;
  endfunction

  // Every-cycle comparison of dut_a against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("core_reset", core_reset_a, (m_ph == 0) ? 4'hf : 4'h0);
      chk("done_mask", done_mask_a, m_mask);
      chk("busy", busy_a, (m_ph == 1 || m_ph == 2));
      chk("all_done", all_done_a, (m_ph == 3));
      chk("timed_out", timed_out_a, (m_ph == 4));
      chk("total", total_a, exp_total());
      chk("cycles", cycles_a, m_cyc);
    end
  end

  typedef struct {int cyc; int core; int val;} ev_t;
  ev_t evq[$];

  task automatic add_ev(input int c, input int core, input int v);
    ev_t e;
    e.cyc = c; e.core = core; e.val = v;
    evq.push_back(e);
  endtask

  // Strobe of core is high in cycle cyc-1 and falls in cycle cyc with result val.
  task automatic run_a(input int ncyc, input int start_at, input int reset_at);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    result_a = '0;
    for (int k = 1; k <= ncyc; k++) begin
      strobe_a = '0;
      start_a = (k == start_at);
      reset = (k == reset_at);
      foreach (evq[e]) begin
        if (evq[e].cyc - 1 == k) strobe_a[evq[e].core] = 1'b1;
        if (evq[e].cyc == k) result_a[evq[e].core*8 +: 8] = 8'(evq[e].val);
      end
      if (start_at != 0 && k == start_at + 3) chk("cycles_ignore_start", cycles_a, k - 1);
      tick();
    end
    start_a = 1'b0;
    reset = 1'b0;
    strobe_a = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_core_reset", core_reset_a, 4'hf);
    chk("rst_done_mask", done_mask_a, 0);
    chk("rst_total", total_a, 0);
    chk("rst_cycles", cycles_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("base_a", page_base_a, {8'd192, 8'd128, 8'd64, 8'd0});
    chk("limit_a", page_limit_a, {8'd255, 8'd191, 8'd127, 8'd63});
    chk("base_b", page_base_b, {8'd170, 8'd85, 8'd0});
    chk("limit_b", page_limit_b, {8'd255, 8'd169, 8'd84});
    reset = 1'b0;
    chk_on = 1'b1;
    tick();

    // Four cores finishing in order.
    evq.delete();
    add_ev(30, 0, 16); add_ev(45, 1, 12); add_ev(60, 2, 14); add_ev(80, 3, 12);
    run_a(87, 0, 0);
    chk("s1_total", total_a, 54);
    chk("s1_cycles", cycles_a, 80);
    chk("s1_mask", done_mask_a, 4'hf);
    chk("s1_all_done", all_done_a, 1);
    chk("s1_core_reset", core_reset_a, 0);

    // Simultaneous falls and a late re-strobe that must be ignored.
    evq.delete();
    add_ev(10, 0, 3); add_ev(20, 1, 5); add_ev(20, 2, 9); add_ev(30, 1, 200); add_ev(40, 3, 7);
    run_a(47, 0, 0);
    chk("s2_total", total_a, 24);
    chk("s2_all_done", all_done_a, 1);

    // Core 3 never reports.
    evq.delete();
    add_ev(30, 0, 16); add_ev(45, 1, 12); add_ev(60, 2, 14);
    run_a(108, 0, 0);
    chk("s3_timed_out", timed_out_a, 1);
    chk("s3_mask", done_mask_a, 4'b0111);
    chk("s3_total", total_a, 42);
    chk("s3_cycles", cycles_a, 100);
    chk("s3_all_done", all_done_a, 0);

    // Start during RUN is ignored; reset mid-RUN returns to idle.
    evq.delete();
    add_ev(10, 0, 16);
    run_a(22, 15, 20);
    chk("s4_core_reset", core_reset_a, 4'hf);
    chk("s4_cycles", cycles_a, 0);
    chk("s4_mask", done_mask_a, 0);
    chk("s4_busy", busy_a, 0);

    // Three-core instance: run, then restart from DONE.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      strobe_b = '0;
      for (int i = 0; i < 3; i++) begin
        if (k == 4 + i) strobe_b[i] = 1'b1;
        if (k == 5 + i) result_b[i*8 +: 8] = 8'(i + 1);
      end
      tick();
    end
    chk("b_all_done", all_done_b, 1);
    chk("b_total", total_b, 6);
    chk("b_cycles", cycles_b, 7);
    chk("b_mask", done_mask_b, 3'b111);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b_restart_total", total_b, 0);
    chk("b_restart_cycles", cycles_b, 0);
    chk("b_restart_busy", busy_b, 1);
    chk("b_restart_mask", done_mask_b, 0);
    tick();

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
